// File: rtl/chan_link_supervisor.sv
// Aurora 8b10b channel link bring-up/recovery supervisor in the clk50 domain.
// Sequences the core reset, waits for channel_up, retries on timeout and re-inits on link faults.
module chan_link_supervisor #(
  parameter int RESET_HOLD     = 64,
  parameter int UP_TIMEOUT     = 5_000_000,
  parameter int ERR_WINDOW     = 50_000_000,
  parameter int SOFT_ERR_LIMIT = 16
) (
  input  logic        clk50,
  input  logic        clk50_reset,
  input  logic        enable,
  input  logic        force_reset,
  input  logic        clear_counts,
  input  logic        channel_up,
  input  logic        hard_err,
  input  logic        soft_err_pulse,
  output logic        link_reset,
  output logic        link_ok,
  output logic [1:0]  state,
  output logic [7:0]  retry_count,
  output logic [15:0] soft_err_count
);

  localparam logic [1:0] ST_HOLD    = 2'd0;
  localparam logic [1:0] ST_RESET   = 2'd1;
  localparam logic [1:0] ST_WAIT_UP = 2'd2;
  localparam logic [1:0] ST_UP      = 2'd3;

  localparam logic [26:0] RESET_LAST = 27'(RESET_HOLD - 1);
  localparam logic [26:0] UP_LAST    = 27'(UP_TIMEOUT - 1);
  localparam logic [26:0] WIN_LAST   = 27'(ERR_WINDOW - 1);
  localparam logic [7:0]  ERR_LIM    = 8'(SOFT_ERR_LIMIT);

  logic        up_meta;
  logic        up_s;
  logic        herr_meta;
  logic        herr_s;
  logic [26:0] timer;
  logic [26:0] win_timer;
  logic [7:0]  win_cnt;
  logic [7:0]  win_cnt_nx;
  logic        win_restart;
  logic [1:0]  state_nx;
  logic        retry_inc;

  // channel_up and hard_err come from the user_clk domain
  always_ff @(posedge clk50 or posedge clk50_reset) begin
    if (clk50_reset) begin
      up_meta   <= 1'b0;
      up_s      <= 1'b0;
      herr_meta <= 1'b0;
      herr_s    <= 1'b0;
    end else begin
      up_meta   <= channel_up;
      up_s      <= up_meta;
      herr_meta <= hard_err;
      herr_s    <= herr_meta;
    end
  end

  // A pulse landing in the window restart cycle is credited to the new window.
  always_comb begin
    win_restart = (win_timer == WIN_LAST);
    win_cnt_nx  = (win_restart ? 8'd0 : win_cnt) + {7'd0, soft_err_pulse};
  end

  always_comb begin
    state_nx  = state;
    retry_inc = 1'b0;
    if (!enable) begin
      state_nx = ST_HOLD;
    end else if (force_reset && (state == ST_WAIT_UP || state == ST_UP)) begin
      state_nx = ST_RESET;
    end else begin
      case (state)
        ST_HOLD: state_nx = ST_RESET;
        ST_RESET: begin
          if (timer == RESET_LAST) state_nx = ST_WAIT_UP;
        end
        ST_WAIT_UP: begin
          if (up_s) begin
            state_nx = ST_UP;
          end else if (timer == UP_LAST) begin
            state_nx  = ST_RESET;
            retry_inc = 1'b1;
          end
        end
        ST_UP: begin
          if (!up_s || herr_s || (win_cnt_nx == ERR_LIM)) begin
            state_nx  = ST_RESET;
            retry_inc = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk50 or posedge clk50_reset) begin
    if (clk50_reset) begin
      state      <= ST_RESET;
      link_reset <= 1'b1;
      link_ok    <= 1'b0;
      timer      <= 27'd0;
    end else begin
      state      <= state_nx;
      link_reset <= (state_nx == ST_HOLD) || (state_nx == ST_RESET);
      link_ok    <= (state_nx == ST_UP);
      timer      <= (state_nx != state) ? 27'd0 : timer + 27'd1;
    end
  end

  // Soft-error window only runs while staying in UP; any other path clears it.
  always_ff @(posedge clk50 or posedge clk50_reset) begin
    if (clk50_reset) begin
      win_timer <= 27'd0;
      win_cnt   <= 8'd0;
    end else if (state == ST_UP && state_nx == ST_UP) begin
      win_timer <= win_restart ? 27'd0 : win_timer + 27'd1;
      win_cnt   <= win_cnt_nx;
    end else begin
      win_timer <= 27'd0;
      win_cnt   <= 8'd0;
    end
  end

  always_ff @(posedge clk50 or posedge clk50_reset) begin
    if (clk50_reset) begin
      retry_count    <= 8'd0;
      soft_err_count <= 16'd0;
    end else if (clear_counts) begin
      retry_count    <= 8'd0;
      soft_err_count <= 16'd0;
    end else begin
      if (retry_inc && retry_count != 8'hFF) retry_count <= retry_count + 8'd1;
      if (soft_err_pulse && soft_err_count != 16'hFFFF) soft_err_count <= soft_err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_chan_link_supervisor.sv
// Directed bench for chan_link_supervisor: bring-up, timeout retries, link drop,
// soft-error windows, overrides, counter clear and asynchronous reset.
module tb_chan_link_supervisor;

  logic        clk50;
  logic        clk50_reset;
  logic        enable;
  logic        force_reset;
  logic        clear_counts;
  logic        channel_up;
  logic        hard_err;
  logic        soft_err_pulse;
  logic        link_reset;
  logic        link_ok;
  logic [1:0]  state;
  logic [7:0]  retry_count;
  logic [15:0] soft_err_count;

  int n_checks = 0;
  int n_fail   = 0;

  chan_link_supervisor #(
    .RESET_HOLD    (8),
    .UP_TIMEOUT    (20),
    .ERR_WINDOW    (100),
    .SOFT_ERR_LIMIT(4)
  ) dut (
    .clk50         (clk50),
    .clk50_reset   (clk50_reset),
    .enable        (enable),
    .force_reset   (force_reset),
    .clear_counts  (clear_counts),
    .channel_up    (channel_up),
    .hard_err      (hard_err),
    .soft_err_pulse(soft_err_pulse),
    .link_reset    (link_reset),
    .link_ok       (link_ok),
    .state         (state),
    .retry_count   (retry_count),
    .soft_err_count(soft_err_count)
  );

  // clock / reset
  initial clk50 = 1'b0;
  always #5 clk50 = ~clk50;

  // driver tasks: everything happens 1 time unit after the rising edge
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk50);
      #1;
    end
  endtask

  task automatic do_reset(input logic up_level);
    clk50_reset    = 1'b1;
    enable         = 1'b1;
    force_reset    = 1'b0;
    clear_counts   = 1'b0;
    hard_err       = 1'b0;
    soft_err_pulse = 1'b0;
    channel_up     = up_level;
    ticks(2);
    clk50_reset = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string name);
    int k = 0;
    while (state !== s && k < budget) begin
      ticks(1);
      k++;
    end
    n_checks++;
    if (state !== s) begin
      n_fail++;
      $display("FAIL %s: state=%0d required=%0d within %0d cycles", name, state, s, budget);
    end
  endtask

  task automatic test_reset();
    clk50_reset = 1'b1;
    enable = 1'b1; force_reset = 1'b0; clear_counts = 1'b0;
    channel_up = 1'b0; hard_err = 1'b0; soft_err_pulse = 1'b0;
    ticks(3);
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL reset_state: got %0d required 1", state); end
    n_checks++; if (link_reset !== 1'b1) begin n_fail++; $display("FAIL reset_link_reset: got %b required 1", link_reset); end
    n_checks++; if (link_ok !== 1'b0) begin n_fail++; $display("FAIL reset_link_ok: got %b required 0", link_ok); end
    n_checks++; if (retry_count !== 8'd0) begin n_fail++; $display("FAIL reset_retry: got %0d required 0", retry_count); end
    n_checks++; if (soft_err_count !== 16'd0) begin n_fail++; $display("FAIL reset_soft: got %0d required 0", soft_err_count); end
    clk50_reset = 1'b0;
  endtask

  task automatic test_bring_up();
    do_reset(1'b0);
    for (int c = 0; c < 8; c++) begin
      n_checks++;
      if (link_reset !== 1'b1 || state !== 2'd1) begin
        n_fail++;
        $display("FAIL bringup_hold_c%0d: link_reset=%b state=%0d required 1/1", c, link_reset, state);
      end
      if (c == 5) channel_up = 1'b1;
      ticks(1);
    end
    n_checks++; if (state !== 2'd2 || link_reset !== 1'b0) begin n_fail++; $display("FAIL bringup_wait_up: state=%0d link_reset=%b required 2/0", state, link_reset); end
    n_checks++; if (link_ok !== 1'b0) begin n_fail++; $display("FAIL bringup_ok_early: got %b required 0", link_ok); end
    ticks(1);
    n_checks++; if (link_ok !== 1'b1 || state !== 2'd3) begin n_fail++; $display("FAIL bringup_up: link_ok=%b state=%0d required 1/3", link_ok, state); end
    n_checks++; if (retry_count !== 8'd0) begin n_fail++; $display("FAIL bringup_retry: got %0d required 0", retry_count); end
  endtask

  task automatic test_link_drop();
    ticks(3);
    channel_up = 1'b0;
    ticks(2);
    n_checks++; if (link_ok !== 1'b1) begin n_fail++; $display("FAIL drop_ok_before: got %b required 1", link_ok); end
    ticks(1);
    n_checks++; if (link_ok !== 1'b0 || link_reset !== 1'b1 || state !== 2'd1) begin n_fail++; $display("FAIL drop_reset: link_ok=%b link_reset=%b state=%0d required 0/1/1", link_ok, link_reset, state); end
    n_checks++; if (retry_count !== 8'd1) begin n_fail++; $display("FAIL drop_retry: got %0d required 1", retry_count); end
    channel_up = 1'b1;
    wait_state(2'd3, 40, "drop_recover");
    hard_err = 1'b1;
    ticks(2);
    n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL herr_before: state=%0d required 3", state); end
    ticks(1);
    hard_err = 1'b0;
    n_checks++; if (state !== 2'd1 || link_ok !== 1'b0 || link_reset !== 1'b1) begin n_fail++; $display("FAIL herr_reset: state=%0d link_ok=%b link_reset=%b required 1/0/1", state, link_ok, link_reset); end
    n_checks++; if (retry_count !== 8'd2) begin n_fail++; $display("FAIL herr_retry: got %0d required 2", retry_count); end
  endtask

  task automatic test_timeout();
    do_reset(1'b0);
    ticks(27);
    n_checks++; if (state !== 2'd2 || retry_count !== 8'd0) begin n_fail++; $display("FAIL timeout_c27: state=%0d retry=%0d required 2/0", state, retry_count); end
    ticks(1);
    n_checks++; if (state !== 2'd1 || retry_count !== 8'd1) begin n_fail++; $display("FAIL timeout_1: state=%0d retry=%0d required 1/1", state, retry_count); end
    ticks(28);
    n_checks++; if (state !== 2'd1 || retry_count !== 8'd2) begin n_fail++; $display("FAIL timeout_2: state=%0d retry=%0d required 1/2", state, retry_count); end
    ticks(28);
    n_checks++; if (state !== 2'd1 || retry_count !== 8'd3) begin n_fail++; $display("FAIL timeout_3: state=%0d retry=%0d required 1/3", state, retry_count); end
    ticks(297 * 28);
    n_checks++; if (retry_count !== 8'd255) begin n_fail++; $display("FAIL timeout_sat: retry=%0d required 255", retry_count); end
  endtask

  task automatic test_soft_err();
    do_reset(1'b1);
    wait_state(2'd3, 20, "soft_bringup");
    // 3 pulses per window at offsets 10, 20 and 99 (99 is the restart cycle)
    for (int w = 0; w < 5; w++) begin
      for (int t = 0; t < 100; t++) begin
        soft_err_pulse = (t == 10 || t == 20 || t == 99);
        ticks(1);
      end
    end
    soft_err_pulse = 1'b0;
    n_checks++; if (state !== 2'd3 || link_ok !== 1'b1) begin n_fail++; $display("FAIL soft_stay_up: state=%0d link_ok=%b required 3/1", state, link_ok); end
    n_checks++; if (soft_err_count !== 16'd15) begin n_fail++; $display("FAIL soft_total: got %0d required 15", soft_err_count); end
    // window 5 already holds the restart-cycle pulse, so offset 30 is the 4th
    for (int t = 0; t < 30; t++) begin
      soft_err_pulse = (t == 10 || t == 20);
      ticks(1);
    end
    soft_err_pulse = 1'b1;
    n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL soft_before_limit: state=%0d required 3", state); end
    ticks(1);
    soft_err_pulse = 1'b0;
    n_checks++; if (state !== 2'd1 || retry_count !== 8'd1) begin n_fail++; $display("FAIL soft_limit: state=%0d retry=%0d required 1/1", state, retry_count); end
    n_checks++; if (soft_err_count !== 16'd18) begin n_fail++; $display("FAIL soft_total2: got %0d required 18", soft_err_count); end
  endtask

  task automatic test_overrides();
    do_reset(1'b1);
    wait_state(2'd3, 20, "ovr_bringup");
    channel_up = 1'b0;
    enable = 1'b0;
    ticks(1);
    n_checks++; if (state !== 2'd0 || link_reset !== 1'b1 || link_ok !== 1'b0) begin n_fail++; $display("FAIL ovr_disable: state=%0d link_reset=%b link_ok=%b required 0/1/0", state, link_reset, link_ok); end
    enable = 1'b1;
    ticks(1);
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL ovr_enable: state=%0d required 1", state); end
    wait_state(2'd2, 20, "ovr_wait_up");
    force_reset = 1'b1;
    ticks(1);
    force_reset = 1'b0;
    n_checks++; if (state !== 2'd1 || retry_count !== 8'd0) begin n_fail++; $display("FAIL ovr_force: state=%0d retry=%0d required 1/0", state, retry_count); end
    force_reset = 1'b1;
    enable = 1'b0;
    ticks(1);
    force_reset = 1'b0;
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL ovr_force_disable: state=%0d required 0", state); end
    enable = 1'b1;
    ticks(5);
    force_reset = 1'b1;
    ticks(1);
    force_reset = 1'b0;
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL ovr_force_in_reset: state=%0d required 1", state); end
    ticks(3);
    n_checks++; if (state !== 2'd2 || retry_count !== 8'd0) begin n_fail++; $display("FAIL ovr_reset_not_restarted: state=%0d retry=%0d required 2/0", state, retry_count); end
  endtask

  task automatic test_clear();
    do_reset(1'b0);
    ticks(5);
    soft_err_pulse = 1'b1;
    ticks(1);
    soft_err_pulse = 1'b0;
    ticks(22);
    n_checks++; if (retry_count !== 8'd1 || soft_err_count !== 16'd1) begin n_fail++; $display("FAIL clear_pre: retry=%0d soft=%0d required 1/1", retry_count, soft_err_count); end
    ticks(27);
    clear_counts = 1'b1;
    soft_err_pulse = 1'b1;
    ticks(1);
    clear_counts = 1'b0;
    soft_err_pulse = 1'b0;
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL clear_timeout: state=%0d required 1", state); end
    n_checks++; if (retry_count !== 8'd0 || soft_err_count !== 16'd0) begin n_fail++; $display("FAIL clear_wins: retry=%0d soft=%0d required 0/0", retry_count, soft_err_count); end
  endtask

  task automatic test_mid_reset();
    do_reset(1'b0);
    ticks(28);
    channel_up = 1'b1;
    soft_err_pulse = 1'b1;
    ticks(1);
    soft_err_pulse = 1'b0;
    wait_state(2'd3, 40, "mid_bringup");
    n_checks++; if (retry_count !== 8'd1 || soft_err_count !== 16'd1) begin n_fail++; $display("FAIL mid_pre: retry=%0d soft=%0d required 1/1", retry_count, soft_err_count); end
    #2;
    clk50_reset = 1'b1;
    #1;
    n_checks++; if (state !== 2'd1 || link_reset !== 1'b1 || link_ok !== 1'b0) begin n_fail++; $display("FAIL mid_async: state=%0d link_reset=%b link_ok=%b required 1/1/0", state, link_reset, link_ok); end
    n_checks++; if (retry_count !== 8'd0 || soft_err_count !== 16'd0) begin n_fail++; $display("FAIL mid_counts: retry=%0d soft=%0d required 0/0", retry_count, soft_err_count); end
    ticks(1);
    clk50_reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bring_up();
    test_link_drop();
    test_timeout();
    test_soft_err();
    test_overrides();
    test_clear();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
